// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-stage and shared-memory handshakes of mem_port_arbiter.
// master is the arbiter's view; slave is the view of the surrounding requesters and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned BE_W = WIDTH / 8;

  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;

  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic [BE_W-1:0]  dm_be;
  logic             dm_gnt;
  logic             dm_rvalid;
  logic [WIDTH-1:0] dm_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [BE_W-1:0]  mem_be;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  logic             stall_if;
  logic             stall_dm;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output stall_if, stall_dm
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  stall_if, stall_dm
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise data always wins a tie.
module mem_port_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              clkEn,
  input logic              flushEn,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned BE_W = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d, last_q, last_d;
  logic             drop_q, drop_d;
  logic             mem_req_q, mem_req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic grant_if, grant_dm, resp, fetch_cancel;
  logic if_rv, dm_rv, if_busy, dm_busy;

  // State and registered request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      drop_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      mem_req_q  <= mem_req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state, arbitration and response routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    grant_if     = 1'b0;
    grant_dm     = 1'b0;
    resp         = 1'b0;
    fetch_cancel = flushEn && (owner_q == OWN_IF);

    if (clkEn && !rst) begin
      case (state_q)
        IDLE: begin
          // A flush in the same cycle keeps fetch out of arbitration entirely
          if (bus.dm_req && bus.if_req && !flushEn) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_dm = (last_q == OWN_IF);
            grant_if = (last_q == OWN_DM);
`else
            grant_dm = 1'b1;
`endif
          end else if (bus.dm_req) begin
            grant_dm = 1'b1;
          end else if (bus.if_req && !flushEn) begin
            grant_if = 1'b1;
          end

          if (grant_dm) begin
            owner_d = OWN_DM;
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            be_d    = bus.dm_be;
          end else if (grant_if) begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            be_d    = '1;
          end

          if (grant_dm || grant_if) begin
            last_d    = owner_d;
            mem_req_d = 1'b1;
            state_d   = ISSUE;
          end
        end
        ISSUE: begin
          if (fetch_cancel) drop_d = 1'b1;
          if (bus.mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = RESP;
          end
        end
        RESP: begin
          if (fetch_cancel) drop_d = 1'b1;
          if (bus.mem_rvalid) begin
            resp    = 1'b1;
            drop_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if_rv = resp && (owner_q == OWN_IF) && !drop_q && !flushEn;
    dm_rv = resp && (owner_q == OWN_DM);
    if (if_rv) if_rdata_d = bus.mem_rdata;
    if (dm_rv) dm_rdata_d = bus.mem_rdata;
  end

  assign if_busy = (state_q != IDLE) && (owner_q == OWN_IF) && !drop_q;
  assign dm_busy = (state_q != IDLE) && (owner_q == OWN_DM);

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.if_rvalid = if_rv;
  assign bus.dm_rvalid = dm_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = dm_rv ? bus.mem_rdata : dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.stall_if  = !rst && (bus.if_req || if_busy) && !if_rv;
  assign bus.stall_dm  = !rst && (bus.dm_req || dm_busy) && !dm_rv;
endmodule
